// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and data-memory wait
// handling with timeout, plus saturating stall/flush performance counters.
module hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ifid_rn,
    input  logic [4:0]  ifid_rm,
    input  logic        ifid_uses_rm,
    input  logic [4:0]  idex_rd,
    input  logic        idex_memtoreg,
    input  logic        idex_regwrite,
    input  logic        br_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwr_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic        mem_err,
    output logic [1:0]  state
);
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned WAIT_W = 4;

    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_MEM_WAIT = 2'b01;
    localparam logic [1:0] ST_ERR      = 2'b10;

    localparam logic [REG_W-1:0]  XZR      = REG_W'(31);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(15);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_q, flush_q;
    logic              load_use, mem_stall;

    assign state     = state_q;
    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

    // Hazard sources; XZR never creates a dependency.
    always_comb begin
        load_use  = idex_memtoreg && idex_regwrite && (idex_rd != XZR) &&
                    ((idex_rd == ifid_rn) || (ifid_uses_rm && (idex_rd == ifid_rm)));
        mem_stall = mem_req && !mem_ready;
    end

    // Next state and Mealy stage controls.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        mem_err_d   = mem_err_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwr_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;

        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_stall) begin
                    if (state_q == ST_RUN) begin
                        state_d = ST_MEM_WAIT;
                        wait_d  = '0;
                    end else if (wait_q == WAIT_MAX) begin
                        state_d   = ST_ERR;
                        mem_err_d = 1'b1;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else begin
                    state_d  = ST_RUN;
                    wait_d   = '0;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    memwr_en = 1'b1;
                    if (br_taken) begin
                        pc_en       = 1'b1;
                        ifid_en     = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (load_use) begin
                        idex_bubble = 1'b1;
                    end else begin
                        pc_en   = 1'b1;
                        ifid_en = 1'b1;
                    end
                end
            end
            ST_ERR: ;
            default: begin
                state_d   = ST_ERR;
                mem_err_d = 1'b1;
            end
        endcase

        // Pipeline is frozen for the whole time reset is held.
        if (!reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwr_en    = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
            if (!pc_en && (stall_q != CNT_MAX)) stall_q <= stall_q + CNT_W'(1);
            if (ifid_flush && (flush_q != CNT_MAX)) flush_q <= flush_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: per-cycle comparison against a behavioural model plus
// directed scenarios with literal expectations.
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ifid_rn, ifid_rm, idex_rd;
    logic        ifid_uses_rm, idex_memtoreg, idex_regwrite;
    logic        br_taken, mem_req, mem_ready;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwr_en, ifid_flush, idex_bubble;
    logic [31:0] stall_cnt, flush_cnt;
    logic        mem_err;
    logic [1:0]  state;

    int checks = 0;
    int passes = 0;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .ifid_rn(ifid_rn), .ifid_rm(ifid_rm), .ifid_uses_rm(ifid_uses_rm),
        .idex_rd(idex_rd), .idex_memtoreg(idex_memtoreg), .idex_regwrite(idex_regwrite),
        .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwr_en(memwr_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: mode flags, cycles spent waiting, and counters.
    bit          m_wait = 1'b0;
    bit          m_err = 1'b0;
    int          m_waited = 0;
    longint      m_stall = 0;
    longint      m_flush = 0;

    always @(negedge clk) begin : model_cmp
        logic [6:0] e;
        logic stalled, lu;
        if (!reset) begin
            m_wait = 1'b0; m_err = 1'b0; m_waited = 0; m_stall = 0; m_flush = 0;
        end
        chk("m_state", 32'(state), m_err ? 32'd2 : (m_wait ? 32'd1 : 32'd0));
        chk("m_mem_err", 32'(mem_err), 32'(m_err));
        chk("m_stall_cnt", stall_cnt, 32'(m_stall));
        chk("m_flush_cnt", flush_cnt, 32'(m_flush));

        stalled = mem_req && !mem_ready;
        lu = idex_memtoreg && idex_regwrite && idex_rd != 5'd31 &&
             (idex_rd == ifid_rn || (ifid_uses_rm && idex_rd == ifid_rm));
        // {pc, ifid, idex, exmem, memwr, flush, bubble}
        if (!reset || m_err || stalled) e = 7'b0000000;
        else if (br_taken)              e = 7'b1111111;
        else if (lu)                    e = 7'b0011101;
        else                            e = 7'b1111100;
        chk("m_pc_en", 32'(pc_en), 32'(e[6]));
        chk("m_ifid_en", 32'(ifid_en), 32'(e[5]));
        chk("m_idex_en", 32'(idex_en), 32'(e[4]));
        chk("m_exmem_en", 32'(exmem_en), 32'(e[3]));
        chk("m_memwr_en", 32'(memwr_en), 32'(e[2]));
        chk("m_ifid_flush", 32'(ifid_flush), 32'(e[1]));
        chk("m_idex_bubble", 32'(idex_bubble), 32'(e[0]));

        if (reset) begin
            if (!e[6] && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (e[1] && m_flush < 64'hFFFF_FFFF) m_flush++;
            if (!m_err) begin
                if (stalled) begin
                    if (m_wait) begin
                        m_waited++;
                        if (m_waited == 16) begin m_err = 1'b1; m_wait = 1'b0; end
                    end else begin
                        m_wait = 1'b1; m_waited = 0;
                    end
                end else begin
                    m_wait = 1'b0; m_waited = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        ifid_rn = 5'd0; ifid_rm = 5'd0; ifid_uses_rm = 1'b0; idex_rd = 5'd0;
        idex_memtoreg = 1'b0; idex_regwrite = 1'b0;
        br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rn,
                          input logic [4:0] rm, input logic uses_rm);
        idle();
        idex_memtoreg = 1'b1; idex_regwrite = 1'b1;
        idex_rd = rd; ifid_rn = rn; ifid_rm = rm; ifid_uses_rm = uses_rm;
    endtask

    task automatic pulse_reset();
        idle(); reset = 1'b0; #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        chk("rst_pc_en", 32'(pc_en), 32'd0);
        tick(); reset = 1'b1; #1;
    endtask

    initial begin
        idle(); reset = 1'b0;
        repeat (2) tick();
        chk("init_state", 32'(state), 32'd0);
        chk("init_memwr_en", 32'(memwr_en), 32'd0);
        reset = 1'b1; #1;
        chk("idle_pc_en", 32'(pc_en), 32'd1);
        tick();

        // Load-use on rn
        set_lu(5'd5, 5'd5, 5'd0, 1'b0); #1;
        chk("lu_pc_en", 32'(pc_en), 32'd0);
        chk("lu_ifid_en", 32'(ifid_en), 32'd0);
        chk("lu_idex_en", 32'(idex_en), 32'd1);
        chk("lu_bubble", 32'(idex_bubble), 32'd1);
        tick();
        chk("lu_stall_cnt", stall_cnt, 32'd1);
        idle(); #1;
        chk("lu_after_pc_en", 32'(pc_en), 32'd1);
        tick();

        // XZR and unused rm never stall; used rm does
        set_lu(5'd31, 5'd31, 5'd0, 1'b0); #1;
        chk("xzr_pc_en", 32'(pc_en), 32'd1);
        tick();
        chk("xzr_stall_cnt", stall_cnt, 32'd1);
        set_lu(5'd7, 5'd0, 5'd7, 1'b0); #1;
        chk("rm_unused_pc_en", 32'(pc_en), 32'd1);
        tick();
        set_lu(5'd7, 5'd0, 5'd7, 1'b1); #1;
        chk("rm_used_pc_en", 32'(pc_en), 32'd0);
        tick();
        chk("rm_stall_cnt", stall_cnt, 32'd2);
        set_lu(5'd5, 5'd5, 5'd0, 1'b0); idex_regwrite = 1'b0; #1;
        chk("no_regwrite_pc_en", 32'(pc_en), 32'd1);
        tick();

        // Branch beats load-use
        pulse_reset();
        set_lu(5'd5, 5'd5, 5'd0, 1'b0); br_taken = 1'b1; #1;
        chk("br_pc_en", 32'(pc_en), 32'd1);
        chk("br_flush", 32'(ifid_flush), 32'd1);
        chk("br_bubble", 32'(idex_bubble), 32'd1);
        tick();
        chk("br_flush_cnt", flush_cnt, 32'd1);
        chk("br_stall_cnt", stall_cnt, 32'd0);

        // Three-cycle memory wait
        pulse_reset();
        idle(); mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; chk("mw_pc_en", 32'(pc_en), 32'd0);
            tick();
            chk("mw_state", 32'(state), 32'd1);
        end
        chk("mw_stall_cnt", stall_cnt, 32'd3);
        mem_ready = 1'b1; #1;
        chk("mw_done_pc_en", 32'(pc_en), 32'd1);
        tick();
        chk("mw_done_state", 32'(state), 32'd0);
        chk("mw_done_stall_cnt", stall_cnt, 32'd3);

        // Branch ignored under mem stall, honoured on completion
        idle(); mem_req = 1'b1; br_taken = 1'b1; #1;
        chk("mwbr_flush", 32'(ifid_flush), 32'd0);
        tick();
        mem_ready = 1'b1; #1;
        chk("mwbr_done_flush", 32'(ifid_flush), 32'd1);
        tick();
        chk("mwbr_flush_cnt", flush_cnt, 32'd1);
        idle(); tick();

        // Timeout into ERR
        pulse_reset();
        idle(); mem_req = 1'b1;
        repeat (16) tick();
        chk("to16_state", 32'(state), 32'd1);
        chk("to16_mem_err", 32'(mem_err), 32'd0);
        tick();
        chk("to17_state", 32'(state), 32'd2);
        chk("to17_mem_err", 32'(mem_err), 32'd1);
        repeat (3) tick();
        chk("to20_stall_cnt", stall_cnt, 32'd20);
        idle(); #1;
        chk("err_pc_en", 32'(pc_en), 32'd0);
        tick();
        chk("err_hold_state", 32'(state), 32'd2);
        pulse_reset();
        chk("err_exit_pc_en", 32'(pc_en), 32'd1);
        tick();
        chk("err_exit_state", 32'(state), 32'd0);

        // Reset abandons a pending wait
        mem_req = 1'b1; tick(); tick();
        chk("abandon_wait_state", 32'(state), 32'd1);
        pulse_reset();
        tick();
        chk("abandon_state", 32'(state), 32'd0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
